sram_ctrl: RTL and testbench
============================

Name: sram_ctrl

Overview:
- Initiator-side controller for the single-port synchronous SRAM model (cs/we/ad/din/dout interface).
- Accepts read/write requests on a valid/ready request channel and drives registered SRAM control signals.
- Captures the read data the SRAM returns one cycle after sampling, and returns it in order on a valid/ready response channel with a small buffer.
- Sits between a bus-side master and the sram_model instance.

Parameters:
- DEPTH, 8, number of SRAM words.
- WIDTH, 32, data width in bits.
- DEPTH_LOG, $clog2(DEPTH), address width.
- RSP_DEPTH, 4, response FIFO entries; power of 2, >= 2.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller accepts request this cycle.
- req_we  in  1  1=write, 0=read.
- req_addr  in  DEPTH_LOG  word address.
- req_wdata  in  WIDTH  write data; ignored for reads.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer takes response.
- rsp_rdata  out  WIDTH  read data, request order.
- init_busy  out  1  init sweep in progress; tied 0 without the optional feature.
- sram_cs  out  1  SRAM chip select.
- sram_we  out  1  SRAM write enable.
- sram_ad  out  DEPTH_LOG  SRAM address.
- sram_din  out  WIDTH  SRAM write data.
- sram_dout  in  WIDTH  SRAM read data, valid the cycle after the SRAM samples a read.

Behaviour:
- Reset (async, active-high) values:
  - sram_cs=0, sram_we=0, sram_ad=0, sram_din=0.
  - rsp_valid=0, rsp_rdata=0, credit count=0, FIFO empty, in-flight flags 0.
  - req_ready=0 while rst is high.
- Reset is legal mid-operation: in-flight reads and buffered responses are discarded, and no response is produced for them.
- Accept = req_valid && req_ready at a posedge.
  - Every accept registers sram_cs=1, sram_we=req_we, sram_ad=req_addr, sram_din=req_wdata for exactly the next cycle.
  - A cycle without an accept registers sram_cs=0 and sram_we=0; sram_ad and sram_din hold their values.
- Writes are posted and produce no response.
- Read pipeline:
  - Accept at edge N -> sram_cs high in cycle N..N+1 -> SRAM samples at N+1.
  - The controller captures sram_dout into the FIFO at edge N+2.
  - rsp_valid is high from edge N+2 when the FIFO was empty. Fixed read latency is 2 cycles.
- Credit count = FIFO occupancy + reads in flight (0..2).
  - +1 on read accept; -1 on rsp handshake; both in the same cycle -> unchanged.
- req_ready = !init_busy && (credit < RSP_DEPTH).
  - Registered or combinational from state only; never depends on req_valid or req_we.
  - Writes are therefore also blocked when credits are full. This is accepted for simplicity.
- Response FIFO:
  - rsp_valid = !empty; rsp_rdata = head entry; head advances on rsp_valid && rsp_ready.
  - Push and pop in the same cycle are legal; occupancy stays unchanged.
  - Read and write pointers wrap modulo RSP_DEPTH.
  - The credit rule guarantees no push when full; an assertion flags overflow.
- Back-to-back accepts: one per cycle, sustained while credits are available. Throughput is 1 request/cycle when rsp_ready=1.
- Same-address write then read on consecutive accepts: the read returns the new data. This follows from SRAM ordering; no forwarding is needed.
- State machine (sram_ctrl_pkg::state_t):
  - INIT: only with the optional feature.
  - RUN: normal operation. Reset state is RUN without the feature.

Optional Feature:
- Macro: SRAM_CTRL_INIT_EN.
- Defined:
  - Reset state is INIT with init_busy=1 and req_ready=0.
  - The controller writes 0 to addresses 0..DEPTH-1, one per cycle: sram_cs=1, sram_we=1, sram_din=0.
  - After the write to DEPTH-1 is issued, it moves to RUN and init_busy falls on the next edge.
  - req_ready may rise in the same cycle init_busy falls.
  - Reset during INIT restarts the sweep at address 0.
- Undefined: no INIT state, init_busy tied to 0, SRAM contents are not cleared.

Decomposition:
- sram_ctrl_pkg holds:
  - state_t enum {INIT, RUN}.
  - Default-parameter localparams.
  - Credit-width helper function, $clog2(RSP_DEPTH+1).
- One sub-module, sram_ctrl_rsp_fifo: parameterised WIDTH/RSP_DEPTH synchronous FIFO with async reset, push/pop/full/empty/count.
- Top-level keeps the FSM, command register, in-flight tracking and credit counter.

Test Plan:
- Write addr 0..7 with data 'h10+i back-to-back, then read 0..7 with rsp_ready=1 -> rsp_rdata='h10..'h17 in order; each rsp_valid exactly 2 cycles after its accept; no bubbles.
- rsp_ready=0, issue 6 reads -> exactly 4 accepted and req_ready low after the 4th; raise rsp_ready -> the remaining 2 are accepted, and all 6 return in order.
- Write addr 3='hAA then immediately read addr 3 -> rsp_rdata='hAA.
- Assert rst while 2 reads are in flight and 2 are buffered -> all outputs at reset values; no stale rsp_valid after release; a new read of addr 5 returns the current contents.
- Simultaneous push/pop with FIFO holding 2 entries -> occupancy stays 2; credits unchanged; data order preserved.
- With SRAM_CTRL_INIT_EN: after reset, init_busy=1 for 8 cycles with sram_ad sweeping 0..7, sram_we=1 and din=0; then read 0..7 -> all return 0.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types, default parameters and helpers for the SRAM initiator controller.
package sram_ctrl_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_DEPTH     = 8;
  localparam int DEF_WIDTH     = 32;
  localparam int DEF_RSP_DEPTH = 4;

  // Counter width able to hold every value 0..rsp_depth inclusive.
  function automatic int credit_width(input int rsp_depth);
    return $clog2(rsp_depth + 1);
  endfunction

endpackage

// File: rtl/sram_ctrl_rsp_fifo.sv
// Response buffer: synchronous FIFO with async reset, head entry shown combinationally.
module sram_ctrl_rsp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int  WIDTH     = DEF_WIDTH,
  parameter int  RSP_DEPTH = DEF_RSP_DEPTH,
  localparam int PTR_W     = $clog2(RSP_DEPTH),
  localparam int CNT_W     = credit_width(RSP_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [RSP_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             pop_en;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(RSP_DEPTH));
  assign count     = count_q;
  assign pop_en    = pop && !empty;
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointers wrap naturally because RSP_DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_en) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop_en})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert (!(push && full && !pop_en));
    end
  end

endmodule

// File: rtl/sram_ctrl.sv
// Initiator-side controller for a single-port synchronous SRAM with in-order read responses.
// Optional power-up clear sweep enabled by defining SRAM_CTRL_INIT_EN.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH_LOG = $clog2(DEPTH),
  parameter int RSP_DEPTH = DEF_RSP_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [DEPTH_LOG-1:0] req_addr,
  input  logic [WIDTH-1:0]     req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_rdata,
  output logic                 init_busy,
  output logic                 sram_cs,
  output logic                 sram_we,
  output logic [DEPTH_LOG-1:0] sram_ad,
  output logic [WIDTH-1:0]     sram_din,
  input  logic [WIDTH-1:0]     sram_dout
);

  localparam int CNT_W = credit_width(RSP_DEPTH);

  logic                 accept;
  logic                 rd_accept;
  logic                 rsp_pop;
  logic                 cs_q, cs_d;
  logic                 we_q, we_d;
  logic [DEPTH_LOG-1:0] ad_q, ad_d;
  logic [WIDTH-1:0]     din_q, din_d;
  logic                 rd1_q, rd2_q;
  logic [CNT_W-1:0]     credit_q, credit_d;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  logic                 init_active;
  logic [DEPTH_LOG-1:0] init_addr;

`ifdef SRAM_CTRL_INIT_EN
  state_t               state_q, state_d;
  logic [DEPTH_LOG-1:0] init_addr_q, init_addr_d;

  assign init_active = (state_q == INIT);
  assign init_addr   = init_addr_q;

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    if (state_q == INIT) begin
      init_addr_d = init_addr_q + DEPTH_LOG'(1);
      if (init_addr_q == DEPTH_LOG'(DEPTH - 1)) begin
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= INIT;
      init_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
    end
  end
`else
  assign init_active = 1'b0;
  assign init_addr   = '0;
`endif

  // Credits cover both buffered responses and reads still in the SRAM pipe.
  assign init_busy = init_active;
  assign req_ready = !rst && !init_active && (credit_q < CNT_W'(RSP_DEPTH));
  assign accept    = req_valid && req_ready;
  assign rd_accept = accept && !req_we;
  assign rsp_pop   = rsp_valid && rsp_ready;

  always_comb begin
    cs_d  = 1'b0;
    we_d  = 1'b0;
    ad_d  = ad_q;
    din_d = din_q;
    if (init_active) begin
      cs_d  = 1'b1;
      we_d  = 1'b1;
      ad_d  = init_addr;
      din_d = '0;
    end else if (accept) begin
      cs_d  = 1'b1;
      we_d  = req_we;
      ad_d  = req_addr;
      din_d = req_wdata;
    end
  end

  always_comb begin
    credit_d = credit_q;
    case ({rd_accept, rsp_pop})
      2'b10:   credit_d = credit_q + CNT_W'(1);
      2'b01:   credit_d = credit_q - CNT_W'(1);
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_q     <= 1'b0;
      we_q     <= 1'b0;
      ad_q     <= '0;
      din_q    <= '0;
      rd1_q    <= 1'b0;
      rd2_q    <= 1'b0;
      credit_q <= '0;
    end else begin
      cs_q     <= cs_d;
      we_q     <= we_d;
      ad_q     <= ad_d;
      din_q    <= din_d;
      rd1_q    <= rd_accept;
      rd2_q    <= rd1_q;
      credit_q <= credit_d;
    end
  end

  assign sram_cs  = cs_q;
  assign sram_we  = we_q;
  assign sram_ad  = ad_q;
  assign sram_din = din_q;

  // rd2_q marks the cycle in which sram_dout carries the read sampled one edge earlier.
  sram_ctrl_rsp_fifo #(
    .WIDTH     (WIDTH),
    .RSP_DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd2_q),
    .push_data (sram_dout),
    .pop       (rsp_ready),
    .head_data (rsp_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rsp_valid = !fifo_empty;

  always @(posedge clk) begin
    if (!rst) begin
      assert (!(rd2_q && fifo_full));
      assert (credit_q == fifo_count + CNT_W'(rd1_q) + CNT_W'(rd2_q));
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: directed scenarios plus random traffic against a queue model.
module tb_sram_ctrl;

  localparam int DEPTH     = 8;
  localparam int WIDTH     = 32;
  localparam int DEPTH_LOG = $clog2(DEPTH);
  localparam int RSP_DEPTH = 4;

  logic                 clk;
  logic                 rst;
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [DEPTH_LOG-1:0] req_addr;
  logic [WIDTH-1:0]     req_wdata;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [WIDTH-1:0]     rsp_rdata;
  logic                 init_busy;
  logic                 sram_cs;
  logic                 sram_we;
  logic [DEPTH_LOG-1:0] sram_ad;
  logic [WIDTH-1:0]     sram_din;
  logic [WIDTH-1:0]     sram_dout;

  sram_ctrl #(
    .DEPTH     (DEPTH),
    .WIDTH     (WIDTH),
    .DEPTH_LOG (DEPTH_LOG),
    .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .init_busy (init_busy),
    .sram_cs   (sram_cs),
    .sram_we   (sram_we),
    .sram_ad   (sram_ad),
    .sram_din  (sram_din),
    .sram_dout (sram_dout)
  );

  // Single-port synchronous SRAM: read data appears the cycle after sampling.
  logic [WIDTH-1:0] sram_mem [DEPTH];
  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) sram_mem[sram_ad] <= sram_din;
      else         sram_dout <= sram_mem[sram_ad];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int               checks = 0;
  int               errors = 0;
  int               cyc    = 0;
  logic [WIDTH-1:0] ref_mem [DEPTH];
  logic [WIDTH-1:0] exp_q [$];
  int               acc_q [$];
  logic             prev_acc = 1'b0;
  logic             prev_we  = 1'b0;
  logic [DEPTH_LOG-1:0] prev_ad  = '0;
  logic [WIDTH-1:0] prev_din   = '0;
  logic [WIDTH-1:0] last_rdata = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, want);
    end
  endtask

  // One clock: check outputs at negedge against the model, record handshakes, advance.
  task automatic cycle(output logic acc);
    logic pop;
    @(negedge clk);
    chk1("sram_cs", sram_cs, prev_acc);
    if (prev_acc) begin
      chk1("sram_we", sram_we, prev_we);
      chk("sram_ad", 32'(sram_ad), 32'(prev_ad));
      chk("sram_din", sram_din, prev_din);
    end
    chk1("init_busy", init_busy, 1'b0);
    chk1("req_ready", req_ready, exp_q.size() < RSP_DEPTH);
    // A read accepted at the edge after negedge c becomes visible at negedge c+3.
    chk1("rsp_valid", rsp_valid, (exp_q.size() > 0) && (acc_q[0] + 3 <= cyc));
    acc = req_valid && req_ready;
    pop = rsp_valid && rsp_ready;
    if (pop) begin
      if (exp_q.size() > 0) begin
        chk("rsp_rdata", rsp_rdata, exp_q[0]);
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
      end
      last_rdata = rsp_rdata;
      $display("[%0d] rsp data=%h", cyc, rsp_rdata);
    end
    if (acc) begin
      if (req_we) begin
        ref_mem[req_addr] = req_wdata;
      end else begin
        exp_q.push_back(ref_mem[req_addr]);
        acc_q.push_back(cyc);
      end
      $display("[%0d] req %s addr=%0d data=%h", cyc, req_we ? "WR" : "RD", req_addr, req_wdata);
    end
    prev_acc = acc;
    prev_we  = req_we;
    prev_ad  = req_addr;
    prev_din = req_wdata;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic issue(input logic we, input logic [DEPTH_LOG-1:0] addr, input logic [WIDTH-1:0] data);
    logic a;
    int   waited;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
    a         = 1'b0;
    waited    = 0;
    while (!a && waited < 40) begin
      cycle(a);
      waited++;
    end
    chk1("issue_accepted", a, 1'b1);
  endtask

  task automatic drain();
    logic a;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) cycle(a);
    chk("drain_outstanding", 32'(exp_q.size()), 32'd0);
    cycle(a);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 1'b0;
    #1;
    chk1("rst_sram_cs", sram_cs, 1'b0);
    chk1("rst_sram_we", sram_we, 1'b0);
    chk("rst_sram_ad", 32'(sram_ad), 32'd0);
    chk("rst_sram_din", sram_din, 32'd0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk1("rst_req_ready", req_ready, 1'b0);
`ifdef SRAM_CTRL_INIT_EN
    chk1("rst_init_busy", init_busy, 1'b1);
`else
    chk1("rst_init_busy", init_busy, 1'b0);
`endif
    exp_q.delete();
    acc_q.delete();
    prev_acc = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
`ifdef SRAM_CTRL_INIT_EN
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
    @(negedge clk);
    chk1("init_busy_start", init_busy, 1'b1);
    chk1("init_cs_idle", sram_cs, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      chk1("init_cs", sram_cs, 1'b1);
      chk1("init_we", sram_we, 1'b1);
      chk("init_ad", 32'(sram_ad), 32'(i));
      chk("init_din", sram_din, 32'd0);
      chk1("init_busy", init_busy, i != DEPTH - 1);
      chk1("init_req_ready", req_ready, i == DEPTH - 1);
      $display("[init] clear addr=%0d", i);
    end
    @(posedge clk);
    #1;
`endif
  endtask

  initial begin
    logic                 a;
    int                   n;
    logic [DEPTH_LOG-1:0] bp_addr [6];

    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    @(posedge clk);
    #1;
    do_reset();

`ifdef SRAM_CTRL_INIT_EN
    for (int i = 0; i < DEPTH; i++) issue(1'b0, DEPTH_LOG'(i), $urandom);
    drain();
`endif

    // Back-to-back writes then reads with a free-flowing consumer.
    rsp_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) issue(1'b1, DEPTH_LOG'(i), 32'h10 + 32'(i));
    for (int i = 0; i < DEPTH; i++) issue(1'b0, DEPTH_LOG'(i), $urandom);
    drain();

    // Backpressure: credits limit outstanding reads to RSP_DEPTH.
    for (int i = 0; i < 6; i++) bp_addr[i] = DEPTH_LOG'($urandom_range(0, DEPTH - 1));
    rsp_ready = 1'b0;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = bp_addr[n];
      req_wdata = $urandom;
      cycle(a);
      if (a) n++;
    end
    chk("bp_accepted_blocked", 32'(n), 32'd4);
    rsp_ready = 1'b1;
    for (int k = 0; k < 30 && n < 6; k++) begin
      req_addr = bp_addr[n];
      cycle(a);
      if (a) n++;
    end
    req_valid = 1'b0;
    chk("bp_accepted_total", 32'(n), 32'd6);
    drain();

    // Write immediately followed by a read of the same address.
    issue(1'b1, DEPTH_LOG'(3), 32'hAA);
    issue(1'b0, DEPTH_LOG'(3), $urandom);
    drain();
    chk("wr_then_rd_same_addr", last_rdata, 32'hAA);

    // Simultaneous push and pop with two entries buffered.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(1'b0, DEPTH_LOG'($urandom_range(0, DEPTH - 1)), $urandom);
    req_valid = 1'b0;
    cycle(a);
    rsp_ready = 1'b1;
    issue(1'b0, DEPTH_LOG'($urandom_range(0, DEPTH - 1)), $urandom);
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    cycle(a);
    drain();

    // Reset with two reads buffered and two still in the SRAM pipe.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(1'b0, DEPTH_LOG'($urandom_range(0, DEPTH - 1)), $urandom);
    do_reset();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (4) cycle(a);
    issue(1'b0, DEPTH_LOG'(5), $urandom);
    drain();

    // Random traffic.
    for (int i = 0; i < DEPTH; i++) issue(1'b1, DEPTH_LOG'(i), $urandom);
    for (int k = 0; k < 300; k++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = ($urandom_range(0, 1) == 1);
      req_addr  = DEPTH_LOG'($urandom_range(0, DEPTH - 1));
      req_wdata = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle(a);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
